pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter stage of the single-cycle RISC core.
- Holds the fetch address in a bank of 1-bit D flip-flops and selects the next PC each cycle: sequential +1, taken branch, or jump.
- Feeds the instruction memory address and supplies pc_plus1 to writeback for link.
- Includes a small RUN/HALT control FSM for debug stop and resume.

Parameters:
PC_WIDTH, 16, width of PC and all target buses (word-addressed)
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC this cycle (hazard or memory wait)
branch_taken  input  1  load branch_target
branch_target  input  PC_WIDTH  branch destination
jump  input  1  load jump_target
jump_target  input  PC_WIDTH  jump destination
halt_req  input  1  request stop after the current update
resume  input  1  leave HALT
pc  output  PC_WIDTH  current fetch address (registered)
pc_plus1  output  PC_WIDTH  pc + 1, combinational, modulo 2^PC_WIDTH
halted  output  1  high while the FSM is in HALT (registered)
wrapped  output  1  sticky flag: PC has wrapped from all-ones to 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_VECTOR, state = RUN, halted = 0, wrapped = 0.
  - Release is sampled at the next clk edge.
- FSM states:
  - RUN: PC updates every non-stalled cycle.
  - HALT: PC frozen.
- FSM transitions:
  - RUN -> HALT when halt_req = 1 at an edge.
  - HALT -> RUN when resume = 1 at an edge.
  - halt_req is ignored in HALT; resume is ignored in RUN.
  - halt_req and resume both high in HALT: resume wins.
- Next-PC priority in RUN with stall = 0:
  - jump -> jump_target
  - else branch_taken -> branch_target
  - else pc_plus1
- stall = 1 in RUN: pc holds; the FSM still honours halt_req.
- Halt timing: the edge that samples halt_req also performs the normal PC update, so the instruction in flight commits. Example: pc = 5, halt_req = 1 -> pc = 6 and halted = 1 after the edge, and pc stays 6 thereafter.
- In HALT: jump, branch_taken and stall are ignored, and pc holds.
- Resume: the first update happens on the edge after the resume edge.
- Wrap-around:
  - pc = all-ones with sequential increment -> pc = 0 and wrapped set.
  - wrapped clears only on reset.
  - Jump or branch to 0 does not set wrapped.
- Latency: one cycle from select inputs to pc; pc_plus1 has zero latency from pc.
- Reset mid-operation (any state, any cycle) immediately forces the reset values; no pending halt or update survives.

Optional Feature:
Macro: PC_INSN_COUNT_EN
- Defined:
  - Adds output insn_count (32 bits).
  - Counts edges where state = RUN and stall = 0, i.e. one per committed instruction.
  - Reset to 0; saturates at 32'hFFFF_FFFF.
  - Frozen in HALT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding constants: ST_RUN = 1'b0, ST_HALT = 1'b1
  - the PC_WIDTH default
  - the RESET_VECTOR default
- One natural sub-module, pc_next_mux: a combinational priority select of jump/branch/increment that also produces pc_plus1 and the wrap-detect signal.
- The FSM, PC register and counters stay in pc_unit.

Test Plan:
- Reset then free-run: rst_n low 2 cycles, then high, no controls -> pc goes 0,1,2,3 on successive edges; halted = 0.
- Priority: at pc = 3, apply jump = 1 (jump_target = 16'h0040) and branch_taken = 1 (branch_target = 16'h0020) together -> pc = 16'h0040. Next cycle branch only -> pc = 16'h0020.
- Stall and halt:
  - stall = 1 for 3 cycles at pc = 8 -> pc stays 8.
  - halt_req with stall = 0 at pc = 8 -> pc = 9, halted = 1.
  - Jump pulses while halted -> pc stays 9.
  - resume -> halted = 0, then pc = 10 on the next edge.
- Wrap: jump to 16'hFFFE, run 2 cycles -> pc = 16'hFFFF then 16'h0000, and wrapped = 1. Jump to 0 after reset -> wrapped stays 0.
- Async reset mid-operation: assert rst_n low between edges while halted at pc = 16'h1234 -> pc = 0 and halted = 0 immediately, without a clock edge.
- With PC_INSN_COUNT_EN: 5 run cycles, 2 stall cycles, 3 halted cycles -> insn_count = 5.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: FSM encoding and parameter defaults.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEF = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select (jump > branch > increment), plus pc_plus1 and sequential wrap detect.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic                seq_wrap
);

    localparam logic [PC_WIDTH-1:0] PcOne = PC_WIDTH'(1);

    always_comb begin
        pc_plus1 = pc + PcOne;
        seq_wrap = 1'b0;
        if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end else begin
            pc_next  = pc_plus1;
            // Only a sequential increment from all-ones counts as a wrap.
            seq_wrap = &pc;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage with RUN/HALT debug FSM and sticky wrap flag.
// Optional committed-instruction counter enabled by defining PC_INSN_COUNT_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                halt_req,
    input  logic                resume,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic                halted,
    output logic                wrapped
`ifdef PC_INSN_COUNT_EN
    ,
    output logic [31:0]         insn_count
`endif
);

    pc_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  wrapped_q, wrapped_d;
    logic [PC_WIDTH-1:0]   pc_next;
    logic                  seq_wrap;
    logic                  advance;

    pc_next_mux #(
        .PC_WIDTH(PC_WIDTH)
    ) u_next_mux (
        .pc           (pc_q),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc_next      (pc_next),
        .pc_plus1     (pc_plus1),
        .seq_wrap     (seq_wrap)
    );

    // The halt edge still commits the in-flight update, so advance ignores halt_req.
    assign advance = (state_q == ST_RUN) && !stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrapped_d = wrapped_q;
        if (advance) begin
            pc_d      = pc_next;
            wrapped_d = wrapped_q | seq_wrap;
        end
        unique case (state_q)
            ST_RUN:  if (halt_req) state_d = ST_HALT;
            ST_HALT: if (resume)   state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VECTOR;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign pc      = pc_q;
    assign halted  = (state_q == ST_HALT);
    assign wrapped = wrapped_q;

`ifdef PC_INSN_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (advance && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign insn_count = count_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit against a behavioural model; define PC_INSN_COUNT_EN to cover the counter.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, halt_req, resume;
    logic [15:0] branch_target, jump_target;
    logic [15:0] pc, pc_plus1;
    logic        halted, wrapped;
`ifdef PC_INSN_COUNT_EN
    logic [31:0] insn_count;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [15:0] pc_m;
    logic        halted_m, wrapped_m;
    longint      cnt_m;

    pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .halted       (halted),
        .wrapped      (wrapped)
`ifdef PC_INSN_COUNT_EN
        ,
        .insn_count   (insn_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        pc_m      = 16'h0000;
        halted_m  = 1'b0;
        wrapped_m = 1'b0;
        cnt_m     = 0;
    endtask

    // Drive one cycle of controls, update the model, and return #1 after the edge.
    task automatic step(input logic s, input logic j, input logic [15:0] jt, input logic b,
                        input logic [15:0] bt, input logic h, input logic r);
        int sum;
        stall = s; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
        halt_req = h; resume = r;
        if (!halted_m) begin
            if (!s) begin
                if (cnt_m < 64'hFFFF_FFFF) cnt_m++;
                if (j) pc_m = jt;
                else if (b) pc_m = bt;
                else begin
                    sum = int'(pc_m) + 1;
                    if (sum == 65536) wrapped_m = 1'b1;
                    pc_m = 16'(sum % 65536);
                end
            end
            if (h) halted_m = 1'b1;
        end else if (r) begin
            halted_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 0; jump = 0; branch_taken = 0; halt_req = 0; resume = 0;
        jump_target = 0; branch_target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (pc !== 16'h0000 || halted !== 1'b0 || wrapped !== 1'b0) begin
            bad++;
            $display("FAIL reset: pc=%h halted=%b wrapped=%b want pc=0000 halted=0 wrapped=0",
                     pc, halted, wrapped);
        end
        total++;
        if (pc_plus1 !== 16'h0001) begin
            bad++;
            $display("FAIL reset_plus1: got %h want 0001", pc_plus1);
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 3; i++) begin
            idle();
            total++;
            if (pc !== 16'(i) || halted !== 1'b0) begin
                bad++;
                $display("FAIL free_run[%0d]: pc=%h halted=%b want pc=%h halted=0",
                         i, pc, halted, 16'(i));
            end
        end
    endtask

    task automatic test_priority();
        step(1'b0, 1'b1, 16'h0040, 1'b1, 16'h0020, 1'b0, 1'b0);
        total++;
        if (pc !== 16'h0040) begin
            bad++;
            $display("FAIL prio_jump: got %h want 0040", pc);
        end
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0, 1'b0);
        total++;
        if (pc !== 16'h0020) begin
            bad++;
            $display("FAIL prio_branch: got %h want 0020", pc);
        end
    endtask

    task automatic test_stall_halt();
        step(1'b0, 1'b1, 16'h0008, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1, 16'h0077, 1'b0, 1'b0);
            total++;
            if (pc !== 16'h0008) begin
                bad++;
                $display("FAIL stall[%0d]: got %h want 0008", i, pc);
            end
        end
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        total++;
        if (pc !== 16'h0009 || halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_edge: pc=%h halted=%b want pc=0009 halted=1", pc, halted);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'(i == 1), 1'b1, 16'h0300, 1'b1, 16'h0200, 1'b1, 1'b0);
            total++;
            if (pc !== 16'h0009 || halted !== 1'b1) begin
                bad++;
                $display("FAIL halted_frozen[%0d]: pc=%h halted=%b want pc=0009 halted=1",
                         i, pc, halted);
            end
        end
        // resume and halt_req together in HALT: resume wins
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        total++;
        if (pc !== 16'h0009 || halted !== 1'b0) begin
            bad++;
            $display("FAIL resume_edge: pc=%h halted=%b want pc=0009 halted=0", pc, halted);
        end
        idle();
        total++;
        if (pc !== 16'h000A) begin
            bad++;
            $display("FAIL after_resume: got %h want 000a", pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0);
        total++;
        if (pc !== 16'h0000 || wrapped !== 1'b0) begin
            bad++;
            $display("FAIL jump_zero: pc=%h wrapped=%b want pc=0000 wrapped=0", pc, wrapped);
        end
        step(1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b0, 1'b0);
        idle();
        total++;
        if (pc !== 16'hFFFF || wrapped !== 1'b0 || pc_plus1 !== 16'h0000) begin
            bad++;
            $display("FAIL pre_wrap: pc=%h plus1=%h wrapped=%b want ffff/0000/0",
                     pc, pc_plus1, wrapped);
        end
        idle();
        total++;
        if (pc !== 16'h0000 || wrapped !== 1'b1) begin
            bad++;
            $display("FAIL wrap: pc=%h wrapped=%b want pc=0000 wrapped=1", pc, wrapped);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0500, 1'b0, 1'b0);
        total++;
        if (wrapped !== 1'b1) begin
            bad++;
            $display("FAIL wrap_sticky: got %b want 1", wrapped);
        end
    endtask

    task automatic test_async_reset();
        realtime t0;
        step(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b1, 1'b0);
        total++;
        if (pc !== 16'h1234 || halted !== 1'b1) begin
            bad++;
            $display("FAIL pre_async: pc=%h halted=%b want pc=1234 halted=1", pc, halted);
        end
        #2;
        t0 = $realtime;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (pc !== 16'h0000 || halted !== 1'b0 || wrapped !== 1'b0 || $realtime - t0 > 2.0) begin
            bad++;
            $display("FAIL async_reset: pc=%h halted=%b wrapped=%b want 0000/0/0",
                     pc, halted, wrapped);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        total++;
        if (pc !== 16'h0001 || halted !== 1'b0) begin
            bad++;
            $display("FAIL post_async: pc=%h halted=%b want 0001/0", pc, halted);
        end
    endtask

    task automatic test_random();
        logic        s, j, b, h, r;
        logic [15:0] jt, bt, exp_plus1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 4) == 0);
            j  = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 5) == 0);
            h  = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 3) == 0);
            jt = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
            bt = 16'($urandom);
            step(s, j, jt, b, bt, h, r);
            exp_plus1 = pc_m + 16'd1;
            total++;
            if (pc !== pc_m || pc_plus1 !== exp_plus1 || halted !== halted_m
                || wrapped !== wrapped_m) begin
                bad++;
                $display("FAIL random[%0d]: pc=%h plus1=%h halted=%b wrapped=%b want %h/%h/%b/%b",
                         i, pc, pc_plus1, halted, wrapped, pc_m, exp_plus1, halted_m, wrapped_m);
            end
`ifdef PC_INSN_COUNT_EN
            total++;
            if (insn_count !== 32'(cnt_m)) begin
                bad++;
                $display("FAIL random_count[%0d]: got %0d want %0d", i, insn_count, cnt_m);
            end
`endif
        end
    endtask

`ifdef PC_INSN_COUNT_EN
    task automatic test_insn_count();
        do_reset();
        total++;
        if (insn_count !== 32'd0) begin
            bad++;
            $display("FAIL count_reset: got %0d want 0", insn_count);
        end
        repeat (4) idle();
        repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0, 1'b0);
        total++;
        if (insn_count !== 32'd5) begin
            bad++;
            $display("FAIL count_plan: got %0d want 5", insn_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_priority();
        test_stall_halt();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef PC_INSN_COUNT_EN
        test_insn_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
